// File: rtl/bus_debug_master_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_debug_master_if
// Description : Bundle of the debug-master byte stream and CPU bus signals.
//               master modport : the bus_debug_master block
//               slave  modport : the surrounding UART / V20 / bus mux side
//   iRxData/iRxValid          command byte stream in
//   oTxData/oTxValid/iTxReady response byte stream out (valid/ready)
//   oHold/iHoldAck            HOLD/HLDA bus arbitration with the V20
//   oAddr/oWrData/iRdData     bus address and data
//   oMemRd/oMemWr/oIoRd/oIoWr one-cycle bus strobes
//   oOwn/oBusy                bus ownership and command-in-progress flags
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_debug_master_if;
  logic [7:0]  iRxData;
  logic        iRxValid;
  logic [7:0]  oTxData;
  logic        oTxValid;
  logic        iTxReady;
  logic        oHold;
  logic        iHoldAck;
  logic [19:0] oAddr;
  logic [7:0]  oWrData;
  logic [7:0]  iRdData;
  logic        oMemRd;
  logic        oMemWr;
  logic        oIoRd;
  logic        oIoWr;
  logic        oOwn;
  logic        oBusy;

  modport master (
    input  iRxData, iRxValid, iTxReady, iHoldAck, iRdData,
    output oTxData, oTxValid, oHold, oAddr, oWrData,
           oMemRd, oMemWr, oIoRd, oIoWr, oOwn, oBusy
  );

  modport slave (
    output iRxData, iRxValid, iTxReady, iHoldAck, iRdData,
    input  oTxData, oTxValid, oHold, oAddr, oWrData,
           oMemRd, oMemWr, oIoRd, oIoWr, oOwn, oBusy
  );
endinterface
`default_nettype wire

// File: rtl/bus_debug_master.sv
`default_nettype none
// ============================================================================
// Module      : bus_debug_master
// Description : Byte-stream driven bus initiator. Parses debug commands
//               ('R','W','I','O'), requests the CPU bus via HOLD/HLDA, runs
//               one V20-style memory or I/O cycle and returns a reply byte.
// Ports       : iClk  - bus clock
//               iRst  - synchronous active-high reset
//               bus   - bus_debug_master_if.master (byte stream, HOLD/HLDA,
//                       address/data, strobes, oOwn, oBusy)
// Parameters  : RD_LAT  - cycles from read strobe to read-data sample
//               TIMEOUT - idle cycles between argument bytes before discard
// Options     : CFG_DBG_AUTOINC_EN - persistent auto-incrementing memory
//               address register and the 'N' (read next) command
// Revision    : 1.0 - initial release
// ============================================================================
module bus_debug_master #(
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned TIMEOUT = 2500000
) (
  input wire                 iClk,
  input wire                 iRst,
  bus_debug_master_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [WW-1:0] C_WAIT_LAST  = WW'(RD_LAT - 1);

  localparam logic [7:0] C_OP_MRD  = 8'h52;  // 'R'
  localparam logic [7:0] C_OP_MWR  = 8'h57;  // 'W'
  localparam logic [7:0] C_OP_IRD  = 8'h49;  // 'I'
  localparam logic [7:0] C_OP_IWR  = 8'h4F;  // 'O'
  localparam logic [7:0] C_OP_NEXT = 8'h4E;  // 'N'
  localparam logic [7:0] C_RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] C_RSP_UNK = 8'h3F;  // '?'
  localparam logic [7:0] C_RSP_ERR = 8'h21;  // '!'

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARGS    = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SETUP   = 3'd3;
  localparam logic [2:0] S_STROBE  = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;
  localparam logic [2:0] S_REPLY   = 3'd7;

  logic [2:0]    state_q,  state_d;
  logic          is_io_q,  is_io_d;
  logic          is_wr_q,  is_wr_d;
  logic [2:0]    args_q,   args_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [WW-1:0] wait_q,   wait_d;
  logic [19:0]   addr_q,   addr_d;
  logic [7:0]    wdata_q,  wdata_d;
  logic [7:0]    txdata_q, txdata_d;
`ifdef CFG_DBG_AUTOINC_EN
  logic [19:0]   mem_addr_q, mem_addr_d;
`endif

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      is_io_q  <= 1'b0;
      is_wr_q  <= 1'b0;
      args_q   <= '0;
      timer_q  <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      txdata_q <= '0;
    end else begin
      state_q  <= state_d;
      is_io_q  <= is_io_d;
      is_wr_q  <= is_wr_d;
      args_q   <= args_d;
      timer_q  <= timer_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      txdata_q <= txdata_d;
    end
  end

`ifdef CFG_DBG_AUTOINC_EN
  always_ff @(posedge iClk) begin
    if (iRst) begin
      mem_addr_q <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    is_io_d  = is_io_q;
    is_wr_d  = is_wr_q;
    args_d   = args_q;
    timer_d  = timer_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    txdata_d = txdata_q;
`ifdef CFG_DBG_AUTOINC_EN
    mem_addr_d = mem_addr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.iRxValid) begin
          // Argument bytes shift in from the bottom, so the address register
          // starts clear; 'I'/'O' then leave the upper bits at zero.
          timer_d = '0;
          addr_d  = '0;
          case (bus.iRxData)
            C_OP_MRD: begin is_io_d = 1'b0; is_wr_d = 1'b0; args_d = 3'd3; state_d = S_ARGS; end
            C_OP_MWR: begin is_io_d = 1'b0; is_wr_d = 1'b1; args_d = 3'd4; state_d = S_ARGS; end
            C_OP_IRD: begin is_io_d = 1'b1; is_wr_d = 1'b0; args_d = 3'd2; state_d = S_ARGS; end
            C_OP_IWR: begin is_io_d = 1'b1; is_wr_d = 1'b1; args_d = 3'd3; state_d = S_ARGS; end
`ifdef CFG_DBG_AUTOINC_EN
            C_OP_NEXT: begin
              is_io_d = 1'b0;
              is_wr_d = 1'b0;
              addr_d  = mem_addr_q;
              state_d = S_REQ;
            end
`endif
            default: begin
              txdata_d = C_RSP_UNK;
              state_d  = S_REPLY;
            end
          endcase
        end
      end

      S_ARGS: begin
        if (bus.iRxValid) begin
          timer_d = '0;
          // The final byte of a write command is the data byte.
          if (is_wr_q && (args_q == 3'd1)) begin
            wdata_d = bus.iRxData;
          end else begin
            // Three address bytes overflow the top of the 20-bit register,
            // which discards the upper nibble of a2.
            addr_d = {addr_q[11:0], bus.iRxData};
          end
          args_d = args_q - 3'd1;
          if (args_q == 3'd1) begin
            state_d = S_REQ;
          end
        end else if (timer_q == C_TIMER_LAST) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_REQ: begin
        if (bus.iHoldAck) begin
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (!bus.iHoldAck) begin
          txdata_d = C_RSP_ERR;
          state_d  = S_REPLY;
        end else begin
          state_d = S_STROBE;
        end
      end

      S_STROBE: begin
        if (!bus.iHoldAck) begin
          txdata_d = C_RSP_ERR;
          state_d  = S_REPLY;
        end else begin
`ifdef CFG_DBG_AUTOINC_EN
          if (!is_io_q) begin
            mem_addr_d = addr_q + 20'd1;
          end
`endif
          if (is_wr_q) begin
            txdata_d = C_RSP_OK;
            state_d  = S_RELEASE;
          end else begin
            wait_d  = '0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (!bus.iHoldAck) begin
          txdata_d = C_RSP_ERR;
          state_d  = S_REPLY;
        end else if (wait_q == C_WAIT_LAST) begin
          txdata_d = bus.iRdData;
          state_d  = S_RELEASE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_RELEASE: begin
        state_d = S_REPLY;
      end

      S_REPLY: begin
        if (bus.iTxReady) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic w_own;
  logic w_strobe;

  always_comb begin
    w_own    = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_WAIT);
    // Strobe is qualified with HLDA so a grant lost in the strobe cycle never
    // reaches the bus.
    w_strobe = (state_q == S_STROBE) && bus.iHoldAck;

    bus.oHold    = w_own || (state_q == S_REQ);
    bus.oOwn     = w_own;
    bus.oMemRd   = w_strobe && !is_io_q && !is_wr_q;
    bus.oMemWr   = w_strobe && !is_io_q &&  is_wr_q;
    bus.oIoRd    = w_strobe &&  is_io_q && !is_wr_q;
    bus.oIoWr    = w_strobe &&  is_io_q &&  is_wr_q;
    bus.oTxValid = (state_q == S_REPLY);
    bus.oTxData  = txdata_q;
    bus.oAddr    = addr_q;
    bus.oWrData  = wdata_q;
    bus.oBusy    = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_debug_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_debug_master
// Description : Directed self-checking bench for bus_debug_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_debug_master;

  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst;

  bus_debug_master_if bus ();

  bus_debug_master #(
    .RD_LAT  (RD_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe monitor
  int          n_mr = 0;
  int          n_mw = 0;
  int          n_ir = 0;
  int          n_iw = 0;
  logic [19:0] last_addr = '0;
  logic [7:0]  last_wd   = '0;
  logic        strobe_any;
  assign strobe_any = bus.oMemRd | bus.oMemWr | bus.oIoRd | bus.oIoWr;

  always @(negedge clk) begin
    if (bus.oMemRd) n_mr++;
    if (bus.oMemWr) n_mw++;
    if (bus.oIoRd)  n_ir++;
    if (bus.oIoWr)  n_iw++;
    if (strobe_any) begin
      last_addr = bus.oAddr;
      last_wd   = bus.oWrData;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input int n);
    logic [7:0] b [5];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    for (int i = 0; i < n; i++) begin
      bus.iRxData  = b[i];
      bus.iRxValid = 1'b1;
      @(negedge clk);
    end
    bus.iRxValid = 1'b0;
  endtask

  task automatic grant(input int delay, input string tag);
    int   waited = 0;
    logic bad    = 1'b0;
    while (!bus.oHold && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_hold"}, bus.oHold, 1);
    for (int i = 0; i < delay; i++) begin
      if (bus.oOwn || strobe_any) bad = 1'b1;
      @(negedge clk);
    end
    if (delay > 0) check({tag, "_nogrant_quiet"}, bad, 0);
    bus.iHoldAck = 1'b1;
  endtask

  task automatic get_reply(input string tag, input logic [7:0] exp);
    int waited = 0;
    while (!bus.oTxValid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, bus.oTxValid, 1);
    check({tag, "_data"}, bus.oTxData, exp);
    bus.iTxReady = 1'b1;
    @(negedge clk);
    bus.iTxReady = 1'b0;
    bus.iHoldAck = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   m0;
    int   w;
    logic flag;

    rst          = 1'b1;
    bus.iRxData  = '0;
    bus.iRxValid = 1'b0;
    bus.iTxReady = 1'b0;
    bus.iHoldAck = 1'b0;
    bus.iRdData  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_hold",   bus.oHold, 0);
    check("rst_own",    bus.oOwn, 0);
    check("rst_strobe", {bus.oMemRd, bus.oMemWr, bus.oIoRd, bus.oIoWr}, 0);
    check("rst_txv",    bus.oTxValid, 0);
    check("rst_txd",    bus.oTxData, 0);
    check("rst_addr",   bus.oAddr, 0);
    check("rst_wd",     bus.oWrData, 0);
    check("rst_busy",   bus.oBusy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Memory write with cycle-exact timing
    m0 = n_mw;
    send(8'h57, 8'h00, 8'h12, 8'h34, 8'hA5, 5);
    check("wr_hold_rise", bus.oHold, 1);
    check("wr_req_own",   bus.oOwn, 0);
    bus.iHoldAck = 1'b1;
    @(negedge clk);
    check("wr_setup_own",  bus.oOwn, 1);
    check("wr_setup_nost", bus.oMemWr, 0);
    check("wr_setup_addr", bus.oAddr, 20'h01234);
    check("wr_setup_wd",   bus.oWrData, 8'hA5);
    @(negedge clk);
    check("wr_strobe", bus.oMemWr, 1);
    @(negedge clk);
    check("wr_rel_own", bus.oOwn, 0);
    check("wr_rel_txv", bus.oTxValid, 0);
    @(negedge clk);
    check("wr_reply_now", bus.oTxValid, 1);
    get_reply("wr", 8'h4B);
    check("wr_count", n_mw - m0, 1);
    check("wr_addr",  last_addr, 20'h01234);
    check("wr_data",  last_wd, 8'hA5);

    // Memory read: data only correct in the RD_LAT-th cycle after the strobe
    m0 = n_mr;
    bus.iRdData = 8'h11;
    send(8'h52, 8'h00, 8'h12, 8'h34, 8'h00, 4);
    grant(0, "rd");
    @(negedge clk);
    check("rd_setup_own", bus.oOwn, 1);
    @(negedge clk);
    check("rd_strobe", bus.oMemRd, 1);
    check("rd_addr",   bus.oAddr, 20'h01234);
    @(negedge clk);
    @(negedge clk);
    bus.iRdData = 8'hA5;
    check("rd_wait_own", bus.oOwn, 1);
    @(negedge clk);
    bus.iRdData = 8'h22;
    check("rd_rel_own", bus.oOwn, 0);
    check("rd_rel_txv", bus.oTxValid, 0);
    @(negedge clk);
    check("rd_reply_now", bus.oTxValid, 1);
    get_reply("rd", 8'hA5);
    check("rd_count", n_mr - m0, 1);

    // I/O write and read
    m0 = n_iw;
    send(8'h4F, 8'h03, 8'hF8, 8'h41, 8'h00, 4);
    grant(0, "iow");
    get_reply("iow", 8'h4B);
    check("iow_count", n_iw - m0, 1);
    check("iow_addr",  last_addr, 20'h003F8);
    check("iow_data",  last_wd, 8'h41);

    m0 = n_ir;
    bus.iRdData = 8'h5C;
    send(8'h49, 8'h00, 8'h60, 8'h00, 8'h00, 3);
    grant(0, "ior");
    get_reply("ior", 8'h5C);
    check("ior_count", n_ir - m0, 1);
    check("ior_addr",  last_addr, 20'h00060);

    // Delayed grant, with a stray byte while waiting that must be dropped
    m0 = n_mw;
    send(8'h57, 8'hF0, 8'h00, 8'h10, 8'h77, 5);
    repeat (3) @(negedge clk);
    send(8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    grant(50, "dg");
    get_reply("dg", 8'h4B);
    check("dg_count", n_mw - m0, 1);
    check("dg_addr",  last_addr, 20'h00010);
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.oTxValid) flag = 1'b1;
      @(negedge clk);
    end
    check("dg_drop_noreply", flag, 0);

    // HLDA dropped during WAIT
    m0 = n_mr;
    send(8'h52, 8'h00, 8'h00, 8'h20, 8'h00, 4);
    grant(0, "ab");
    w = 0;
    while (!bus.oMemRd && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("ab_strobe", bus.oMemRd, 1);
    @(negedge clk);
    bus.iHoldAck = 1'b0;
    @(negedge clk);
    check("ab_hold", bus.oHold, 0);
    check("ab_own",  bus.oOwn, 0);
    get_reply("ab", 8'h21);
    check("ab_count", n_mr - m0, 1);

    // Unknown opcode with ready already high: completes in the rising cycle
    bus.iTxReady = 1'b1;
    send(8'h58, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    check("x_valid", bus.oTxValid, 1);
    check("x_data",  bus.oTxData, 8'h3F);
    @(negedge clk);
    bus.iTxReady = 1'b0;
    check("x_idle",   bus.oBusy, 0);
    check("x_txv_lo", bus.oTxValid, 0);

    // Timeout in ARGS, then a fresh command works
    send(8'h52, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    flag = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 5; i++) begin
      if (bus.oTxValid || bus.oHold) flag = 1'b1;
      @(negedge clk);
    end
    check("to_noreply", flag, 0);
    check("to_idle",    bus.oBusy, 0);
    m0 = n_mr;
    bus.iRdData = 8'h6B;
    send(8'h52, 8'h00, 8'h00, 8'h05, 8'h00, 4);
    grant(0, "to_rd");
    get_reply("to_rd", 8'h6B);
    check("to_rd_count", n_mr - m0, 1);
    check("to_rd_addr",  last_addr, 20'h00005);

`ifdef CFG_DBG_AUTOINC_EN
    // Auto-increment wraps 0xFFFFF -> 0x00000
    bus.iRdData = 8'h5A;
    send(8'h52, 8'h0F, 8'hFF, 8'hFF, 8'h00, 4);
    grant(0, "ai_r");
    get_reply("ai_r", 8'h5A);
    check("ai_r_addr", last_addr, 20'hFFFFF);
    m0 = n_mr;
    send(8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    grant(0, "ai_n");
    get_reply("ai_n", 8'h5A);
    check("ai_n_count", n_mr - m0, 1);
    check("ai_n_addr",  last_addr, 20'h00000);
`else
    send(8'h4E, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    get_reply("n_unknown", 8'h3F);
`endif

    // Reset asserted during WAIT
    send(8'h52, 8'h00, 8'h00, 8'h30, 8'h00, 4);
    grant(0, "rw");
    w = 0;
    while (!bus.oMemRd && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rw_strobe", bus.oMemRd, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rw_own",  bus.oOwn, 0);
    check("rw_hold", bus.oHold, 0);
    check("rw_txv",  bus.oTxValid, 0);
    check("rw_addr", bus.oAddr, 0);
    rst          = 1'b0;
    bus.iHoldAck = 1'b0;
    m0 = n_mr + n_mw + n_ir + n_iw;
    repeat (10) @(negedge clk);
    check("rw_nostrobe", (n_mr + n_mw + n_ir + n_iw) - m0, 0);
    check("rw_busy",     bus.oBusy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
